// File: rtl/reg_bus_arbiter.sv
// Two-requester arbiter for the asynchronous control-register bus with setup/strobe/hold access timing.
// Define REG_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise req0 has fixed priority.
module reg_bus_arbiter #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [1:0]            be0,
  input  logic [1:0]            be1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bus_en,
  output logic                  bus_rd,
  output logic                  bus_wr,
  output logic [1:0]            bus_be,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_oe,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       owner;
  logic       cur_we;
  logic       grant;
  logic       grant_sel;
  logic       sel_we;
`ifdef REG_ARB_ROUND_ROBIN_EN
  logic       last_grant;
`endif

  // sel_we is the direction of the access that next_state belongs to, so outputs can be registered
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    grant      = req0 | req1;
`ifdef REG_ARB_ROUND_ROBIN_EN
    grant_sel  = (req0 && req1) ? ~last_grant : req1;
`else
    grant_sel  = ~req0;
`endif
    sel_we     = cur_we;
    case (state)
      IDLE: begin
        if (grant) begin
          next_state = SETUP;
          sel_we     = grant_sel ? we1 : we0;
        end
      end
      SETUP: begin
        next_state = STROBE;
        cnt_next   = STROBE_LOAD;
      end
      STROBE: begin
        if (cnt == 4'd0) next_state = HOLD;
        else             cnt_next   = cnt - 4'd1;
      end
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Command latch at grant time plus registered bus outputs derived from next_state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= 1'b0;
      cur_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_en    <= 1'b0;
      bus_oe    <= 1'b0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
`ifdef REG_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      if (state == IDLE && grant) begin
        owner     <= grant_sel;
        cur_we    <= sel_we;
        bus_be    <= grant_sel ? be1 : be0;
        bus_addr  <= grant_sel ? addr1 : addr0;
        bus_wdata <= grant_sel ? wdata1 : wdata0;
`ifdef REG_ARB_ROUND_ROBIN_EN
        last_grant <= grant_sel;
`endif
      end
      bus_en <= (next_state != IDLE);
      bus_oe <= (next_state != IDLE) && sel_we;
      bus_rd <= (next_state == STROBE) && !sel_we;
      bus_wr <= (next_state == STROBE) && sel_we;
      ack0   <= (next_state == HOLD) && !owner;
      ack1   <= (next_state == HOLD) && owner;
      if (state == STROBE && cnt == 4'd0 && !cur_we) rdata <= bus_rdata;
    end
  end

endmodule
